// File: rtl/stream_arb_pkg.sv
// ============================================================================
// Module : stream_arb_pkg
// Brief  : Shared constants for the stream round-robin arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stream_arb_pkg;

    // Output-register occupancy state
    localparam logic [0:0] c_st_empty = 1'b0;
    localparam logic [0:0] c_st_full  = 1'b1;

    localparam int GRANT_CNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin picker; searches upward from last+1.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic [ID_W-1:0]    grant,
    output logic               any
);

    logic [ID_W-1:0] w_idx;

    // Scan farthest offset first so the nearest requester after last overwrites.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        w_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = ID_W'((int'(last) + k) % NUM_REQ);
            if (req[w_idx]) begin
                grant = w_idx;
                any   = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/stream_rr_arbiter.sv
// ============================================================================
// Module : stream_rr_arbiter
// Brief  : N-to-1 valid/ready round-robin arbiter with a registered output
//          stage; define ARB_STATS_EN to add per-requester grant counters.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          s_vld,
    output logic [NUM_REQ-1:0]          s_rdy,
    input  logic [NUM_REQ*DATA_W-1:0]   s_data,
    output logic                        m_vld,
    input  logic                        m_rdy,
    output logic [DATA_W-1:0]           m_data,
`ifdef ARB_STATS_EN
    output logic [NUM_REQ*GRANT_CNT_W-1:0] grant_cnt,
`endif
    output logic [$clog2(NUM_REQ)-1:0]  m_id
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [DATA_W-1:0] r_data;
    logic [ID_W-1:0]   r_id;
    logic [ID_W-1:0]   r_last;
    logic [ID_W-1:0]   w_grant;
    logic              w_any;
    logic              w_can_load;
    logic              w_hs;
    logic [DATA_W-1:0] w_data_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign w_data_arr[i] = s_data[i*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req   (s_vld),
        .last  (r_last),
        .grant (w_grant),
        .any   (w_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_empty;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_empty: if (w_hs) w_state_nxt = c_st_full;
            c_st_full:  if (!w_hs && m_rdy) w_state_nxt = c_st_empty;
            default:    w_state_nxt = c_st_empty;
        endcase
    end

    // Reset masks the handshake so no word is accepted on a reset edge.
    always_comb begin
        w_can_load = (r_state == c_st_empty) || m_rdy;
        w_hs       = w_any && w_can_load && !rst;
        s_rdy      = '0;
        if (w_hs) s_rdy[w_grant] = 1'b1;
        m_vld      = (r_state == c_st_full);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_id   <= '0;
            r_last <= ID_W'(NUM_REQ - 1);
        end else if (w_hs) begin
            r_data <= w_data_arr[w_grant];
            r_id   <= w_grant;
            r_last <= w_grant;
        end
    end

    assign m_data = r_data;
    assign m_id   = r_id;

`ifdef ARB_STATS_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
        logic [GRANT_CNT_W-1:0] r_cnt;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (s_vld[i] && s_rdy[i] && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
        assign grant_cnt[i*GRANT_CNT_W +: GRANT_CNT_W] = r_cnt;
    end
`else
    // Statistics disabled: no counters are built.
`endif

endmodule

`default_nettype wire

// File: tb/tb_stream_rr_arbiter.sv
// ============================================================================
// Module : tb_stream_rr_arbiter
// Brief  : Randomised + directed bench for stream_rr_arbiter against a
//          cycle-level reference model (ARB_STATS_EN adds the counter test).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_rr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        s_vld;
    logic [NUM_REQ-1:0]        s_rdy;
    logic [NUM_REQ*DATA_W-1:0] s_data;
    logic                      m_vld;
    logic                      m_rdy;
    logic [DATA_W-1:0]         m_data;
    logic [1:0]                m_id;
`ifdef ARB_STATS_EN
    logic [NUM_REQ*16-1:0]     grant_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit          mdl_vld;
    logic [31:0] mdl_data;
    int          mdl_id;
    int          mdl_last;
    int          mdl_cnt [NUM_REQ];
    logic [31:0] deliv_q [$];

    always #5 clk = ~clk;

    stream_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_vld     (s_vld),
        .s_rdy     (s_rdy),
        .s_data    (s_data),
        .m_vld     (m_vld),
        .m_rdy     (m_rdy),
        .m_data    (m_data),
`ifdef ARB_STATS_EN
        .grant_cnt (grant_cnt),
`endif
        .m_id      (m_id)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // First requester at or after last+1, wrapping; -1 when none.
    function automatic int rr_first(input logic [NUM_REQ-1:0] req, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int j;
            j = (last + k) % NUM_REQ;
            if (((req >> j) & 1) != 0) return j;
        end
        return -1;
    endfunction

    // Compare one cycle against the model, then advance model and clock.
    task automatic step();
        int          g;
        bit          can;
        logic [3:0]  exp_rdy;
        #1;
        g       = rr_first(s_vld, mdl_last);
        can     = !mdl_vld || m_rdy;
        exp_rdy = (rst || g < 0 || !can) ? 4'b0 : 4'(1 << g);
        check_eq("s_rdy", s_rdy, exp_rdy);
        check_eq("m_vld", m_vld, mdl_vld);
        if (mdl_vld) begin
            check_eq("m_data", m_data, mdl_data);
            check_eq("m_id", m_id, mdl_id);
        end
        if (rst) begin
            mdl_vld  = 0;
            mdl_data = '0;
            mdl_id   = 0;
            mdl_last = NUM_REQ - 1;
            for (int i = 0; i < NUM_REQ; i++) mdl_cnt[i] = 0;
        end else begin
            if (mdl_vld && m_rdy) begin
                deliv_q.push_back(mdl_data);
                mdl_vld = 0;
            end
            if (g >= 0 && can) begin
                mdl_vld  = 1;
                mdl_data = s_data[g*DATA_W +: DATA_W];
                mdl_id   = g;
                mdl_last = g;
                if (mdl_cnt[g] < 16'hFFFF) mdl_cnt[g]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_fixed_data();
        for (int i = 0; i < NUM_REQ; i++) s_data[i*DATA_W +: DATA_W] = 32'h100 + i;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        s_vld = 4'b1111;
        m_rdy = 1'b1;
        set_fixed_data();
        mdl_vld  = 0;
        mdl_data = '0;
        mdl_id   = 0;
        mdl_last = NUM_REQ - 1;
        for (int i = 0; i < NUM_REQ; i++) mdl_cnt[i] = 0;
        @(posedge clk);
        #1;

        // Reset held two cycles with every requester active
        step();
        step();
        check_eq("rst_m_vld", m_vld, 0);
        check_eq("rst_s_rdy", s_rdy, 0);
        check_eq("rst_m_data", m_data, 0);
        check_eq("rst_m_id", m_id, 0);
        rst = 1'b0;
        #1;
        check_eq("first_grant", s_rdy, 4'b0001);
        step();
        check_eq("first_id", m_id, 0);

        // Fairness rotation with all requesters active
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("fair_id", m_id, i % 4);
            check_eq("fair_vld", m_vld, 1);
            check_eq("fair_data", m_data, 32'h100 + (i % 4));
        end

        // Backpressure holds the word and blocks producers
        do_reset();
        s_vld = 4'b0010;
        step();
        s_vld = 4'b1111;
        m_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("bp_s_rdy", s_rdy, 0);
            step();
            check_eq("bp_data", m_data, 32'h101);
            check_eq("bp_id", m_id, 1);
        end
        s_vld = 4'b0000;
        m_rdy = 1'b1;
        deliv_q.delete();
        step();
        step();
        check_eq("bp_count", deliv_q.size(), 1);
        if (deliv_q.size() > 0) check_eq("bp_word", deliv_q[0], 32'h101);
        check_eq("bp_drained", m_vld, 0);

        // Lone requester gets every slot
        do_reset();
        deliv_q.delete();
        s_vld = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("sparse_id", m_id, 2);
            check_eq("sparse_vld", m_vld, 1);
        end
        s_vld = 4'b0000;
        step();
        check_eq("sparse_words", deliv_q.size(), 4);

        // Reset while a word is held
        do_reset();
        s_vld = 4'b0100;
        m_rdy = 1'b0;
        step();
        s_vld = 4'b0000;
        step();
        deliv_q.delete();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("mid_rst_vld", m_vld, 0);
        s_vld = 4'b1111;
        m_rdy = 1'b1;
        #1;
        check_eq("mid_rst_grant", s_rdy, 4'b0001);
        step();
        check_eq("mid_rst_lost", deliv_q.size(), 0);

        // Randomised traffic
        for (int c = 0; c < 400; c++) begin
            rst    = ($urandom_range(0, 49) == 0);
            s_vld  = 4'($urandom);
            m_rdy  = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NUM_REQ; i++) s_data[i*DATA_W +: DATA_W] = $urandom;
            step();
        end
        rst = 1'b0;

`ifdef ARB_STATS_EN
        do_reset();
        s_vld = 4'b0010;
        m_rdy = 1'b1;
        for (int c = 0; c < 70000; c++) step();
        for (int i = 0; i < NUM_REQ; i++) begin
            check_eq("grant_cnt", grant_cnt[i*16 +: 16], (i == 1) ? 16'hFFFF : 16'h0);
            check_eq("grant_cnt_mdl", grant_cnt[i*16 +: 16], 16'(mdl_cnt[i]));
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
